// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared constants, FSM states and floor-mask helpers for the elevator scheduler
package elevator_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int FLOOR_W    = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DN   = 2'd2,
        DOOR_OPEN = 2'd3
    } state_e;

    function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(f)) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i < int'(f)) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [FLOOR_W-1:0] encode(input logic [NUM_FLOORS-1:0] v);
        logic [FLOOR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (v[i]) idx = FLOOR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/door_timer.sv
// rtl/door_timer.sv - door hold counter; load/reload restart a DOOR_CYCLES-long window
module door_timer #(
    parameter int DOOR_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic reload_i,
    output logic done_o
);

    logic [7:0] count_q, count_d;

    // Count holds DOOR_CYCLES-1 in the first open cycle, so done marks the last one.
    always_comb begin
        count_d = count_q;
        if (load_i || reload_i) begin
            count_d = 8'(DOOR_CYCLES - 1);
        end else if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == 8'd0);

endmodule

// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - four-floor elevator scheduler: request latching, travel FSM, door control
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] floor_sensor,
    input  logic [NUM_FLOORS-1:0] hall_up,
    input  logic [NUM_FLOORS-1:0] hall_dn,
    input  logic [NUM_FLOORS-1:0] car_req,
    output logic                  up,
    output logic                  down,
    output logic                  stop,
    output logic                  open_door,
    output logic [FLOOR_W-1:0]    monitor,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam logic [NUM_FLOORS-1:0] HUP_VALID = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] HDN_VALID = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
    localparam logic [FLOOR_W-1:0]    TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [FLOOR_W-1:0]    BOT_FLOOR = '0;

    state_e                state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic [NUM_FLOORS-1:0] car_q, car_d, hup_q, hup_d, hdn_q, hdn_d;
    logic                  dir_up_q, dir_up_d;

    logic [NUM_FLOORS-1:0] hup_m, hdn_m, pend, here, door_mask;
    logic [NUM_FLOORS-1:0] clr_car, clr_hup, clr_hdn;
    logic                  sensor_ok, in_door, reload, door_done, load;
    logic [FLOOR_W-1:0]    sensor_idx;
    logic                  pend_above, pend_below, pend_above_s, pend_below_s;

    assign hup_m        = hall_up & HUP_VALID;
    assign hdn_m        = hall_dn & HDN_VALID;
    assign pend         = car_q | hup_q | hdn_q;
    assign here         = NUM_FLOORS'(1) << floor_q;
    assign sensor_ok    = $onehot(floor_sensor);
    assign sensor_idx   = encode(floor_sensor);
    assign in_door      = (state_q == DOOR_OPEN);
    assign pend_above   = |(pend & above_mask(floor_q));
    assign pend_below   = |(pend & below_mask(floor_q));
    assign pend_above_s = |(pend & above_mask(sensor_idx));
    assign pend_below_s = |(pend & below_mask(sensor_idx));

    // Presses at the open floor are absorbed and only extend the door window.
    assign door_mask = in_door ? here : '0;
    assign reload    = in_door && |((car_req | hup_m | hdn_m) & here);
    assign load      = (state_d == DOOR_OPEN) && !in_door;

    door_timer #(
        .DOOR_CYCLES(DOOR_CYCLES)
    ) u_door_timer (
        .clk      (clk),
        .rst_n    (reset),
        .load_i   (load),
        .reload_i (reload),
        .done_o   (door_done)
    );

    always_comb begin
        state_d  = state_q;
        dir_up_d = dir_up_q;
        clr_car  = '0;
        clr_hup  = '0;
        clr_hdn  = '0;
        case (state_q)
            IDLE: begin
                if (|(pend & here)) begin
                    state_d = DOOR_OPEN;
                    clr_car = here;
                    clr_hup = here;
                    clr_hdn = here;
                end else if (pend_above) begin
                    state_d  = MOVE_UP;
                    dir_up_d = 1'b1;
                end else if (pend_below) begin
                    state_d  = MOVE_DN;
                    dir_up_d = 1'b0;
                end
            end
            MOVE_UP: begin
                if (sensor_ok && (|((car_q | hup_q) & floor_sensor) || sensor_idx == TOP_FLOOR ||
                                  (|(hdn_q & floor_sensor) && !pend_above_s))) begin
                    state_d = DOOR_OPEN;
                    clr_car = floor_sensor;
                    clr_hup = floor_sensor;
                    if (!pend_above_s) clr_hdn = floor_sensor;
                end
            end
            MOVE_DN: begin
                if (sensor_ok && (|((car_q | hdn_q) & floor_sensor) || sensor_idx == BOT_FLOOR ||
                                  (|(hup_q & floor_sensor) && !pend_below_s))) begin
                    state_d = DOOR_OPEN;
                    clr_car = floor_sensor;
                    clr_hdn = floor_sensor;
                    if (!pend_below_s) clr_hup = floor_sensor;
                end
            end
            DOOR_OPEN: begin
                if (door_done && !reload) begin
                    if (dir_up_q ? pend_above : pend_below) begin
                        state_d = dir_up_q ? MOVE_UP : MOVE_DN;
                    end else if (dir_up_q ? pend_below : pend_above) begin
                        state_d  = dir_up_q ? MOVE_DN : MOVE_UP;
                        dir_up_d = !dir_up_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clears are applied after sets so service wins over a same-edge press.
    assign floor_d = sensor_ok ? sensor_idx : floor_q;
    assign car_d   = (car_q | (car_req & ~door_mask)) & ~clr_car;
    assign hup_d   = (hup_q | (hup_m & ~door_mask)) & ~clr_hup;
    assign hdn_d   = (hdn_q | (hdn_m & ~door_mask)) & ~clr_hdn;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            floor_q  <= '0;
            car_q    <= '0;
            hup_q    <= '0;
            hdn_q    <= '0;
            dir_up_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            car_q    <= car_d;
            hup_q    <= hup_d;
            hdn_q    <= hdn_d;
            dir_up_q <= dir_up_d;
        end
    end

    assign up        = (state_q == MOVE_UP);
    assign down      = (state_q == MOVE_DN);
    assign open_door = (state_q == DOOR_OPEN);
    assign stop      = (state_q == IDLE) || (state_q == DOOR_OPEN);
    assign monitor   = floor_q;
    assign pending   = pend;

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb/tb_elevator_scheduler.sv - table-driven scoreboard bench for elevator_scheduler
module tb_elevator_scheduler;

    localparam int DC = 8;
    localparam logic [3:0] O_IDLE = 4'b0010;
    localparam logic [3:0] O_UP   = 4'b1000;
    localparam logic [3:0] O_DN   = 4'b0100;
    localparam logic [3:0] O_DOOR = 4'b0011;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] floor_sensor = 4'b0001;
    logic [3:0] hall_up = 4'b0000;
    logic [3:0] hall_dn = 4'b0000;
    logic [3:0] car_req = 4'b0000;
    logic       up, down, stop, open_door;
    logic [1:0] monitor;
    logic [3:0] pending;

    elevator_scheduler #(.DOOR_CYCLES(DC)) dut (
        .clk          (clk),
        .reset        (reset),
        .floor_sensor (floor_sensor),
        .hall_up      (hall_up),
        .hall_dn      (hall_dn),
        .car_req      (car_req),
        .up           (up),
        .down         (down),
        .stop         (stop),
        .open_door    (open_door),
        .monitor      (monitor),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sens;
        logic [3:0] car;
        logic [3:0] hup;
        logic [3:0] hdn;
        logic [9:0] exp;
    } vec_t;

    vec_t       table_q[$];
    logic [9:0] sb_q[$];
    int         n_checks = 0;
    int         n_fail = 0;

    function automatic logic [9:0] dut_out();
        return {up, down, stop, open_door, monitor, pending};
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: out(up,dn,stop,door)=%b mon=%0d pend=%b, expected out=%b mon=%0d pend=%b",
                     name, act[9:6], act[5:4], act[3:0], exp[9:6], exp[5:4], exp[3:0]);
        end
    endtask

    task automatic vec(input logic [3:0] s, input logic [3:0] c, input logic [3:0] u,
                       input logic [3:0] d, input logic [3:0] o, input logic [1:0] m,
                       input logic [3:0] p);
        table_q.push_back('{s, c, u, d, {o, m, p}});
    endtask

    task automatic mv(input logic [3:0] s, input logic [3:0] o, input logic [1:0] m,
                      input logic [3:0] p);
        vec(s, 4'b0, 4'b0, 4'b0, o, m, p);
    endtask

    task automatic door(input logic [3:0] s, input int n, input logic [1:0] m, input logic [3:0] p);
        for (int k = 0; k < n; k++) mv(s, O_DOOR, m, p);
    endtask

    task automatic run_table(input string seg);
        vec_t v;
        int   idx;
        idx = 0;
        while (table_q.size() > 0) begin
            v = table_q.pop_front();
            floor_sensor = v.sens;
            car_req      = v.car;
            hall_up      = v.hup;
            hall_dn      = v.hdn;
            sb_q.push_back(v.exp);
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", seg, idx), dut_out(), sb_q.pop_front());
            n_checks++;
            if ($onehot({up, down, stop}) !== 1'b1) begin
                n_fail++;
                $display("FAIL %s[%0d]_onehot: up/down/stop=%b, expected exactly one set",
                         seg, idx, {up, down, stop});
            end
            idx++;
        end
        car_req = 4'b0;
        hall_up = 4'b0;
        hall_dn = 4'b0;
    endtask

    task automatic pulse_reset(input string name, input logic [3:0] s);
        reset        = 1'b0;
        floor_sensor = s;
        car_req      = 4'b0;
        hall_up      = 4'b0;
        hall_dn      = 4'b0;
        #1;
        check({name, "_async"}, dut_out(), {O_IDLE, 2'd0, 4'b0000});
        @(posedge clk);
        #1;
        check({name, "_hold"}, dut_out(), {O_IDLE, 2'd0, 4'b0000});
        reset = 1'b1;
    endtask

    initial begin
        // Single car call: latch, move, stop, timed door, idle.
        pulse_reset("rst0", 4'b0001);
        vec(4'b0001, 4'b0100, 4'b0, 4'b0, O_IDLE, 2'd0, 4'b0100);
        mv(4'b0001, O_UP,   2'd0, 4'b0100);
        mv(4'b0010, O_UP,   2'd1, 4'b0100);
        mv(4'b0100, O_DOOR, 2'd2, 4'b0000);
        door(4'b0100, DC - 1, 2'd2, 4'b0000);
        mv(4'b0100, O_IDLE, 2'd2, 4'b0000);
        mv(4'b0100, O_IDLE, 2'd2, 4'b0000);
        run_table("single");

        // Up sweep skipping a down call, then reversal to serve it.
        pulse_reset("rst1", 4'b0001);
        vec(4'b0001, 4'b1000, 4'b0100, 4'b0010, O_IDLE, 2'd0, 4'b1110);
        mv(4'b0001, O_UP,   2'd0, 4'b1110);
        mv(4'b0010, O_UP,   2'd1, 4'b1110);
        mv(4'b0100, O_DOOR, 2'd2, 4'b1010);
        door(4'b0100, DC - 1, 2'd2, 4'b1010);
        mv(4'b0100, O_UP,   2'd2, 4'b1010);
        mv(4'b0100, O_UP,   2'd2, 4'b1010);
        mv(4'b1000, O_DOOR, 2'd3, 4'b0010);
        door(4'b1000, DC - 1, 2'd3, 4'b0010);
        mv(4'b1000, O_DN,   2'd3, 4'b0010);
        mv(4'b1000, O_DN,   2'd3, 4'b0010);
        mv(4'b0100, O_DN,   2'd2, 4'b0010);
        mv(4'b0010, O_DOOR, 2'd1, 4'b0000);
        door(4'b0010, DC - 1, 2'd1, 4'b0000);
        mv(4'b0010, O_IDLE, 2'd1, 4'b0000);
        run_table("sweep");

        // Ignored hall bits, up-priority, multi-hot sensor, then a call during the door.
        vec(4'b0010, 4'b0, 4'b1000, 4'b0001, O_IDLE, 2'd1, 4'b0000);
        mv(4'b0010, O_IDLE, 2'd1, 4'b0000);
        vec(4'b0010, 4'b1001, 4'b0, 4'b0, O_IDLE, 2'd1, 4'b1001);
        mv(4'b0010, O_UP,   2'd1, 4'b1001);
        mv(4'b0110, O_UP,   2'd1, 4'b1001);
        mv(4'b0100, O_UP,   2'd2, 4'b1001);
        mv(4'b1000, O_DOOR, 2'd3, 4'b0001);
        vec(4'b1000, 4'b0010, 4'b0, 4'b0, O_DOOR, 2'd3, 4'b0011);
        door(4'b1000, DC - 2, 2'd3, 4'b0011);
        mv(4'b1000, O_DN,   2'd3, 4'b0011);
        mv(4'b0100, O_DN,   2'd2, 4'b0011);
        run_table("prio");

        // Reset mid-descent with two requests pending.
        pulse_reset("rst_mid", 4'b0100);
        mv(4'b0100, O_IDLE, 2'd2, 4'b0000);
        mv(4'b0100, O_IDLE, 2'd2, 4'b0000);
        mv(4'b0100, O_IDLE, 2'd2, 4'b0000);
        run_table("post_rst");

        // Door reload: re-press at door cycle 5 stretches the door to 5+DC cycles.
        vec(4'b0100, 4'b0100, 4'b0, 4'b0, O_IDLE, 2'd2, 4'b0100);
        mv(4'b0100, O_DOOR, 2'd2, 4'b0000);
        door(4'b0100, 4, 2'd2, 4'b0000);
        vec(4'b0100, 4'b0100, 4'b0, 4'b0, O_DOOR, 2'd2, 4'b0000);
        door(4'b0100, DC - 1, 2'd2, 4'b0000);
        mv(4'b0100, O_IDLE, 2'd2, 4'b0000);
        run_table("reload");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/elevator_scheduler.md
ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 The block SHALL have parameter DOOR_CYCLES, default 8, giving the number of cycles open_door stays high per stop (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port floor_sensor, input, 4, one-hot car-at-floor sensor, bit i = floor i+1.
REQ-005 The block SHALL have port hall_up, input, 4, level up-call buttons; bit 3 is ignored.
REQ-006 The block SHALL have port hall_dn, input, 4, level down-call buttons; bit 0 is ignored.
REQ-007 The block SHALL have port car_req, input, 4, level in-car floor buttons.
REQ-008 The block SHALL have outputs up, down, stop, open_door, each 1 bit, as motor and door commands.
REQ-009 The block SHALL have output monitor, 2 bits, the current floor index (0 = floor 1).
REQ-010 The block SHALL have output pending, 4 bits, the OR of latched requests per floor.

Function
REQ-011 Pending registers SHALL set on any clock edge where the matching input is high and SHALL stay set until served.
REQ-012 The floor register SHALL load the sensor index on any edge where floor_sensor is exactly one-hot; zero or multi-hot values SHALL be ignored.
REQ-013 The FSM SHALL have states IDLE, MOVE_UP, MOVE_DN, DOOR_OPEN and SHALL decide using register values from before the edge.
REQ-014 Outputs are registered-state decodes: up=MOVE_UP; down=MOVE_DN; open_door=DOOR_OPEN; stop=IDLE or DOOR_OPEN; exactly one of up/down/stop is high at all times.
REQ-015 IDLE transitions: any request at the current floor -> DOOR_OPEN; else any request above -> MOVE_UP; else any request below -> MOVE_DN; else stay IDLE. When requests exist both above and below, MOVE_UP wins.
REQ-016 In MOVE_UP, with the sensor one-hot at floor f, the FSM SHALL go to DOOR_OPEN on that edge if any of these holds: car_req[f], hall_up[f], f==3, or (hall_dn[f] and nothing pending above f).
REQ-017 MOVE_DN SHALL mirror REQ-016: stop for car_req[f], hall_dn[f], f==0, or (hall_up[f] and nothing pending below f).
REQ-018 Entering DOOR_OPEN SHALL clear car_req[f] and the hall call in the travel direction; when the stop was a reversal (or came from IDLE), it SHALL clear both hall calls at f.
REQ-019 DOOR_OPEN SHALL last exactly DOOR_CYCLES cycles.
REQ-020 A new request at the current floor during DOOR_OPEN SHALL be cleared without latching and SHALL reload the door timer.
REQ-021 On DOOR_OPEN exit, the FSM SHALL keep the previous direction if requests remain that way, else reverse if requests exist the other way, else go to IDLE.
REQ-022 A request set and cleared on the same edge SHALL resolve to cleared (service wins).
REQ-023 Latency SHALL be: from a request first sampled in IDLE to the up/down/open_door assertion, exactly 2 edges; from a qualifying sensor edge to up/down deassertion, 1 edge.

Reset
REQ-024 While reset=0, the block SHALL force state IDLE, floor 0, all pending bits 0, and door timer 0, asynchronously.
REQ-025 During reset the outputs SHALL be stop=1, up=0, down=0, open_door=0, monitor=0, pending=0.
REQ-026 Reset asserted mid-move or mid-door SHALL discard all requests; after release, the block SHALL stay in IDLE until a new request arrives.

Structure
REQ-027 Package elevator_pkg SHALL hold NUM_FLOORS=4, FLOOR_W=2 and the FSM state enumeration.
REQ-028 The design SHALL contain one sub-module, door_timer (load, reload, done), implementing REQ-019/020; all other logic SHALL be in elevator_scheduler.

Verification
REQ-029 The bench SHALL check: reset, floor 0, car_req=0100 pulsed 1 cycle -> pending=0100; up high 2 edges later; sensor 0100 -> stop, open_door for 8 cycles, monitor=2, pending=0000, then IDLE.
REQ-030 The bench SHALL check: car at floor 0 moving up to car_req[3], with hall_dn[1] and hall_up[2] raised -> passes floor 1 and stops at floor 2, then floor 3; then reverses to serve floor 1 (down).
REQ-031 The bench SHALL check: car idle at floor 1, hall_up[3]... ignored bit set alone -> stays IDLE, pending=0000; car_req[0] and car_req[3] together -> MOVE_UP first.
REQ-032 The bench SHALL check: in DOOR_OPEN at floor 2, car_req[2] re-pressed at door cycle 5 -> open_door total 5+8 cycles, pending[2]=0.
REQ-033 The bench SHALL check: floor_sensor=0110 while moving -> monitor unchanged, no stop.
REQ-034 The bench SHALL check: reset pulsed low mid MOVE_DN with 2 pending requests -> up=down=0, stop=1, pending=0 immediately; IDLE after release.
